// File: rtl/arith_pkg.sv
// rtl/arith_pkg.sv - shared mode and FSM encodings for the serial arithmetic units
package arith_pkg;

  localparam logic [1:0] MODE_PASS = 2'b00;
  localparam logic [1:0] MODE_NEG  = 2'b01;
  localparam logic [1:0] MODE_ABS  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/One_bit_adder.sv
// rtl/One_bit_adder.sv - single-bit full-adder cell
module One_bit_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  // plain full-adder equations
  always_comb begin
    sum  = a ^ b ^ cin;
    cout = (a & b) | (a & cin) | (b & cin);
  end

endmodule

// File: rtl/serial_twos_complement.sv
// rtl/serial_twos_complement.sv - bit-serial negate / abs / pass unit, LSB first
module serial_twos_complement
  import arith_pkg::*;
#(
  parameter int WIDTH = 9,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf,
  output logic             busy
);

  localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] result_q;
  logic [CNT_W-1:0] cnt_q;
  logic             invert_q;
  logic             carry_q;
  logic             ovf_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;

  logic             invert_next;
  logic             bit_sum;
  logic             bit_cout;

  // invert decision for the operand being offered; reserved mode falls to pass
  always_comb begin
    invert_next = 1'b0;
    case (in_mode)
      MODE_PASS: invert_next = 1'b0;
      MODE_NEG:  invert_next = 1'b1;
      MODE_ABS:  invert_next = in_data[WIDTH-1];
      default:   invert_next = 1'b0;
    endcase
  end

  // negation as (~x + 1): the +1 enters through the initial carry, second operand is zero
  One_bit_adder u_adder (
    .a    (shift_q[0] ^ invert_q),
    .b    (1'b0),
    .cin  (carry_q),
    .sum  (bit_sum),
    .cout (bit_cout)
  );

  // control FSM with datapath registers; DONE spends one cycle settling before out_valid rises
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      shift_q     <= '0;
      result_q    <= '0;
      cnt_q       <= '0;
      invert_q    <= 1'b0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid && in_ready_q) begin
            shift_q    <= in_data;
            result_q   <= '0;
            invert_q   <= invert_next;
            carry_q    <= invert_next;
            ovf_q      <= invert_next && (in_data == MIN_VAL);
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state      <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          result_q <= {bit_sum, result_q[WIDTH-1:1]};
          shift_q  <= {1'b0, shift_q[WIDTH-1:1]};
          carry_q  <= bit_cout;
          if (cnt_q == LAST_BIT) begin
            cnt_q <= '0;
            state <= ST_DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_DONE: begin
          if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state       <= ST_IDLE;
          end else begin
            out_valid_q <= 1'b1;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
          state       <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = result_q;
  assign out_ovf   = ovf_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_serial_twos_complement.sv
// tb/tb_serial_twos_complement.sv - self-checking bench for serial_twos_complement
module tb_serial_twos_complement;

  logic        clk;
  logic        rst_n;
  logic        sel;
  logic        iv;
  logic        ordy;
  logic [31:0] din;
  logic [1:0]  md;

  logic        ir9, ov9, ovf9, busy9;
  logic [8:0]  od9;
  logic        ir16, ov16, ovf16, busy16;
  logic [15:0] od16;

  logic        ir, ov, ovf, busy;
  logic [31:0] od;

  int passed;
  int fails;
  int total;

  serial_twos_complement #(.WIDTH(9)) dut9 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (iv & ~sel),
    .in_ready  (ir9),
    .in_data   (din[8:0]),
    .in_mode   (md),
    .out_valid (ov9),
    .out_ready (ordy & ~sel),
    .out_data  (od9),
    .out_ovf   (ovf9),
    .busy      (busy9)
  );

  serial_twos_complement #(.WIDTH(16)) dut16 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (iv & sel),
    .in_ready  (ir16),
    .in_data   (din[15:0]),
    .in_mode   (md),
    .out_valid (ov16),
    .out_ready (ordy & sel),
    .out_data  (od16),
    .out_ovf   (ovf16),
    .busy      (busy16)
  );

  assign ir   = sel ? ir16   : ir9;
  assign ov   = sel ? ov16   : ov9;
  assign ovf  = sel ? ovf16  : ovf9;
  assign busy = sel ? busy16 : busy9;
  assign od   = sel ? {16'd0, od16} : {23'd0, od9};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // reference: arithmetic on the operand read as a signed WIDTH-bit number
  function automatic void model(input int w, input logic [31:0] x, input logic [1:0] m,
                                output logic [31:0] r, output logic o);
    logic [31:0] mask, minv, neg;
    logic        is_neg;
    mask   = (32'd1 << w) - 32'd1;
    minv   = 32'd1 << (w - 1);
    is_neg = (x >= minv);
    neg    = (32'd0 - x) & mask;
    case (m)
      2'b01:   r = neg;
      2'b10:   r = is_neg ? neg : x;
      default: r = x;
    endcase
    o = ((m == 2'b01) || (m == 2'b10 && is_neg)) && (x == minv);
  endfunction

  task automatic do_op(input logic [31:0] x, input logic [1:0] m,
                       output logic [31:0] r, output logic o, output int lat);
    din = x;
    md  = m;
    iv  = 1'b1;
    chk("accept_ready", {31'd0, ir}, 32'd1);
    tick();
    iv  = 1'b0;
    lat = 0;
    while (!ov && lat < 200) begin
      tick();
      lat++;
    end
    chk("done_seen", {31'd0, ov}, 32'd1);
    chk("busy_in_done", {31'd0, busy}, 32'd1);
    r = od;
    o = ovf;
    tick();
    chk("idle_ready", {31'd0, ir}, 32'd1);
    chk("idle_valid_low", {31'd0, ov}, 32'd0);
  endtask

  task automatic run_check(input string tag, input logic [31:0] x, input logic [1:0] m);
    logic [31:0] r, er;
    logic        o, eo;
    int          lat, w;
    w = sel ? 16 : 9;
    do_op(x, m, r, o, lat);
    model(w, x, m, er, eo);
    chk({tag, "_data"}, r, er);
    chk({tag, "_ovf"}, {31'd0, o}, {31'd0, eo});
    chk({tag, "_lat"}, lat, w + 1);
  endtask

  initial begin
    logic [31:0] held, x;
    logic [1:0]  m;
    passed = 0;
    fails  = 0;
    total  = 0;
    sel    = 1'b0;
    iv     = 1'b0;
    ordy   = 1'b1;
    din    = '0;
    md     = 2'b00;
    rst_n  = 1'b0;
    tick();
    tick();
    rst_n  = 1'b1;
    tick();

    chk("rst_in_ready", {31'd0, ir}, 32'd1);
    chk("rst_out_valid", {31'd0, ov}, 32'd0);
    chk("rst_out_data", od, 32'd0);
    chk("rst_out_ovf", {31'd0, ovf}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);

    run_check("neg_1", 32'h001, 2'b01);
    chk("neg_1_direct", od, 32'h1FF);
    run_check("abs_m10", 32'h1F6, 2'b10);
    chk("abs_m10_direct", od, 32'h00A);
    run_check("abs_p10", 32'h00A, 2'b10);
    run_check("neg_min", 32'h100, 2'b01);
    chk("neg_min_direct", od, 32'h100);
    run_check("abs_min", 32'h100, 2'b10);
    run_check("neg_zero", 32'h000, 2'b01);
    chk("neg_zero_direct", od, 32'h000);
    run_check("pass_min", 32'h100, 2'b00);
    run_check("rsv_neg", 32'h1F6, 2'b11);

    // back-pressure: result must hold while downstream stalls
    ordy = 1'b0;
    din  = 32'h005;
    md   = 2'b01;
    iv   = 1'b1;
    tick();
    iv   = 1'b0;
    for (int i = 0; i < 200 && !ov; i++) tick();
    chk("bp_valid", {31'd0, ov}, 32'd1);
    held = od;
    chk("bp_data", held, 32'h1FB);
    for (int i = 0; i < 5; i++) begin
      iv  = 1'b1;
      din = 32'h033;
      md  = 2'b00;
      tick();
      chk("bp_hold_valid", {31'd0, ov}, 32'd1);
      chk("bp_hold_data", od, held);
      chk("bp_in_ready", {31'd0, ir}, 32'd0);
    end
    iv   = 1'b0;
    ordy = 1'b1;
    tick();
    chk("bp_release_valid", {31'd0, ov}, 32'd0);
    chk("bp_release_ready", {31'd0, ir}, 32'd1);
    chk("bp_release_busy", {31'd0, busy}, 32'd0);

    // reset in the middle of shifting
    din = 32'h0AB;
    md  = 2'b01;
    iv  = 1'b1;
    tick();
    iv  = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("mid_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", {31'd0, ir}, 32'd1);
    chk("mid_rst_valid", {31'd0, ov}, 32'd0);
    chk("mid_rst_data", od, 32'd0);
    chk("mid_rst_ovf", {31'd0, ovf}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    run_check("post_rst", 32'h0AB, 2'b01);

    // random sweep on both widths with occasional corner operands
    for (int s = 0; s < 2; s++) begin
      sel = (s == 1);
      tick();
      for (int i = 0; i < 30; i++) begin
        x = $urandom;
        x = x & (sel ? 32'hFFFF : 32'h1FF);
        case ($urandom_range(0, 7))
          0: x = sel ? 32'h8000 : 32'h100;
          1: x = 32'd0;
          default: ;
        endcase
        m = 2'($urandom_range(0, 3));
        run_check(sel ? "rnd16" : "rnd9", x, m);
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
